// File: rtl/mem_bus_arbiter_rw_pkg.sv
// Shared types and sizing helpers for the read/write bus arbiter.
package mem_bus_arbiter_rw_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } arb_op_t;

  localparam int ADDR_WIDTH = 32;

  // Channel-index width; a single channel still needs one bit.
  function automatic int arb_ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_bus_arbiter_rw_rr_priority_pick.sv
// Round-robin pick: first set request at or after ptr, wrapping to 0.
module rr_priority_pick #(
  parameter int NUM_CH = 3,
  parameter int IDX_W  = 2
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [IDX_W-1:0]  ptr,
  output logic [NUM_CH-1:0] gnt,
  output logic [IDX_W-1:0]  idx,
  output logic              any
);

  int c;

  // Scan from the farthest slot back to ptr so the nearest request wins last.
  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    c   = 0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      c = (int'(ptr) + k) % NUM_CH;
      if (req[c]) begin
        any    = 1'b1;
        idx    = IDX_W'(c);
        gnt    = '0;
        gnt[c] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_bus_arbiter_rw.sv
// N-to-1 round-robin arbiter of read/write controllers onto one device port,
// one transaction outstanding, with a response watchdog.
module mem_bus_arbiter_rw
  import mem_bus_arbiter_rw_pkg::*;
#(
  parameter int NUM_CH    = 3,
  parameter int WIDTH     = 32,
  parameter int TIMEOUT   = 1024,
  parameter int ADDR_W    = ADDR_WIDTH,
  parameter int WORD_SIZE = WIDTH / 8,
  parameter int ARB_CH_W  = arb_ch_w(NUM_CH)
) (
  input  logic                               CLK,
  input  logic                               RST_N,
  input  logic [NUM_CH-1:0][ADDR_W-1:0]      c_read_addr,
  input  logic [NUM_CH-1:0]                  c_read_addr_valid,
  output logic [NUM_CH-1:0]                  c_read_addr_ready,
  output logic [WIDTH-1:0]                   c_read_data,
  output logic [NUM_CH-1:0]                  c_read_data_valid,
  input  logic [NUM_CH-1:0][ADDR_W-1:0]      c_write_addr,
  input  logic [NUM_CH-1:0]                  c_write_addr_valid,
  input  logic [NUM_CH-1:0][WIDTH-1:0]       c_write_data,
  output logic [NUM_CH-1:0]                  c_write_addr_ready,
  output logic [NUM_CH-1:0]                  c_write_resp_valid,
  input  logic [NUM_CH-1:0][WORD_SIZE-1:0]   c_strobe,
  input  logic [NUM_CH-1:0][1:0]             c_size,
  input  logic [NUM_CH-1:0]                  c_lu,
  output logic [ADDR_W-1:0]                  d_read_addr,
  output logic                               d_read_addr_valid,
  output logic [ADDR_W-1:0]                  d_write_addr,
  output logic                               d_write_addr_valid,
  output logic [WIDTH-1:0]                   d_write_data,
  output logic [WORD_SIZE-1:0]               d_strobe,
  output logic [1:0]                         d_size,
  output logic                               d_lu,
  input  logic                               d_read_addr_ready,
  input  logic [WIDTH-1:0]                   d_read_data,
  input  logic                               d_read_data_valid,
  input  logic                               d_write_addr_ready,
  input  logic                               d_write_resp_valid,
  output logic                               timeout_err,
  output logic [ARB_CH_W-1:0]                timeout_ch
);

  localparam int CNT_W = $clog2(TIMEOUT + 2);

  arb_state_t          state, state_n;
  arb_op_t             op;
  logic [ARB_CH_W-1:0] g, ptr, pick_idx;
  logic [NUM_CH-1:0]   req, pick_gnt;
  logic                pick_any, tmo, done, tmo_fire, rsp_in;
  logic [CNT_W-1:0]    cnt;

  assign req = c_read_addr_valid | c_write_addr_valid;

  rr_priority_pick #(.NUM_CH(NUM_CH), .IDX_W(ARB_CH_W)) u_pick (
    .req (req),
    .ptr (ptr),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

  // Request payload follows the registered grant; only the valids are gated.
  assign d_read_addr  = c_read_addr[g];
  assign d_write_addr = c_write_addr[g];
  assign d_write_data = c_write_data[g];
  assign d_strobe     = c_strobe[g];
  assign d_size       = c_size[g];
  assign d_lu         = c_lu[g];

  assign tmo = (TIMEOUT != 0) && (cnt == CNT_W'(TIMEOUT));

  // Everything is forced idle while RST_N is low so an abandoned transaction
  // cannot leak a response in the reset cycle itself.
  always_comb begin
    state_n            = state;
    d_read_addr_valid  = 1'b0;
    d_write_addr_valid = 1'b0;
    c_read_addr_ready  = '0;
    c_write_addr_ready = '0;
    c_read_data_valid  = '0;
    c_write_resp_valid = '0;
    c_read_data        = '0;
    done               = 1'b0;
    tmo_fire           = 1'b0;
    rsp_in             = 1'b0;
    if (RST_N) begin
      unique case (state)
        IDLE: if (pick_any) state_n = ADDR;
        ADDR: begin
          d_write_addr_valid = (op == OP_WRITE);
          d_read_addr_valid  = (op == OP_READ);
          if (tmo || ((op == OP_WRITE) ? d_write_addr_ready : d_read_addr_ready)) begin
            if (op == OP_WRITE) c_write_addr_ready[g] = 1'b1;
            else                c_read_addr_ready[g]  = 1'b1;
            state_n = tmo ? IDLE : RESP;
          end
          if (tmo) begin
            tmo_fire = 1'b1;
            done     = 1'b1;
            if (op == OP_WRITE) c_write_resp_valid[g] = 1'b1;
            else                c_read_data_valid[g]  = 1'b1;
          end
        end
        RESP: begin
          rsp_in = (op == OP_WRITE) ? d_write_resp_valid : d_read_data_valid;
          // A real response in the watchdog cycle still wins.
          if (rsp_in || tmo) begin
            done     = 1'b1;
            tmo_fire = !rsp_in;
            state_n  = IDLE;
            if (op == OP_WRITE) c_write_resp_valid[g] = 1'b1;
            else begin
              c_read_data_valid[g] = 1'b1;
              if (rsp_in) c_read_data = d_read_data;
            end
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state       <= IDLE;
      op          <= OP_READ;
      g           <= '0;
      ptr         <= '0;
      cnt         <= '0;
      timeout_err <= 1'b0;
      timeout_ch  <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && pick_any) begin
        g   <= pick_idx;
        op  <= (|(c_write_addr_valid & pick_gnt)) ? OP_WRITE : OP_READ;
        cnt <= '0;
      end else if (state != IDLE) begin
        cnt <= cnt + 1'b1;
      end
      if (done) ptr <= (g == ARB_CH_W'(NUM_CH - 1)) ? '0 : g + 1'b1;
      if (tmo_fire) begin
        timeout_err <= 1'b1;
        if (!timeout_err) timeout_ch <= g;
      end
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter_rw.sv
// Directed bench for mem_bus_arbiter_rw: vector table plus corner sequences.
module tb_mem_bus_arbiter_rw;

  logic CLK, RST_N;

  // 3-channel, 32-bit, short watchdog instance
  logic [2:0][31:0] c_read_addr, c_write_addr, c_write_data;
  logic [2:0]       c_read_addr_valid, c_read_addr_ready, c_read_data_valid;
  logic [2:0]       c_write_addr_valid, c_write_addr_ready, c_write_resp_valid, c_lu;
  logic [31:0]      c_read_data;
  logic [2:0][3:0]  c_strobe;
  logic [2:0][1:0]  c_size;
  logic [31:0]      d_read_addr, d_write_addr, d_write_data, d_read_data;
  logic             d_read_addr_valid, d_write_addr_valid, d_lu;
  logic [3:0]       d_strobe;
  logic [1:0]       d_size;
  logic             d_read_addr_ready, d_read_data_valid, d_write_addr_ready, d_write_resp_valid;
  logic             timeout_err;
  logic [1:0]       timeout_ch;

  // 3-channel, 128-bit instance
  logic [2:0][31:0]  w_c_read_addr, w_c_write_addr;
  logic [2:0][127:0] w_c_write_data;
  logic [2:0]        w_c_read_addr_valid, w_c_read_addr_ready, w_c_read_data_valid;
  logic [2:0]        w_c_write_addr_valid, w_c_write_addr_ready, w_c_write_resp_valid, w_c_lu;
  logic [127:0]      w_c_read_data, w_d_write_data, w_d_read_data;
  logic [2:0][15:0]  w_c_strobe;
  logic [2:0][1:0]   w_c_size;
  logic [31:0]       w_d_read_addr, w_d_write_addr;
  logic              w_d_read_addr_valid, w_d_write_addr_valid, w_d_lu;
  logic [15:0]       w_d_strobe;
  logic [1:0]        w_d_size;
  logic              w_d_read_addr_ready, w_d_read_data_valid, w_d_write_addr_ready, w_d_write_resp_valid;
  logic              w_timeout_err;
  logic [1:0]        w_timeout_ch;

  int n_tests = 0;
  int n_fail  = 0;

  mem_bus_arbiter_rw #(.NUM_CH(3), .WIDTH(32), .TIMEOUT(8)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .c_read_addr(c_read_addr), .c_read_addr_valid(c_read_addr_valid),
    .c_read_addr_ready(c_read_addr_ready), .c_read_data(c_read_data),
    .c_read_data_valid(c_read_data_valid), .c_write_addr(c_write_addr),
    .c_write_addr_valid(c_write_addr_valid), .c_write_data(c_write_data),
    .c_write_addr_ready(c_write_addr_ready), .c_write_resp_valid(c_write_resp_valid),
    .c_strobe(c_strobe), .c_size(c_size), .c_lu(c_lu),
    .d_read_addr(d_read_addr), .d_read_addr_valid(d_read_addr_valid),
    .d_write_addr(d_write_addr), .d_write_addr_valid(d_write_addr_valid),
    .d_write_data(d_write_data), .d_strobe(d_strobe), .d_size(d_size), .d_lu(d_lu),
    .d_read_addr_ready(d_read_addr_ready), .d_read_data(d_read_data),
    .d_read_data_valid(d_read_data_valid), .d_write_addr_ready(d_write_addr_ready),
    .d_write_resp_valid(d_write_resp_valid),
    .timeout_err(timeout_err), .timeout_ch(timeout_ch)
  );

  mem_bus_arbiter_rw #(.NUM_CH(3), .WIDTH(128)) dut_w (
    .CLK(CLK), .RST_N(RST_N),
    .c_read_addr(w_c_read_addr), .c_read_addr_valid(w_c_read_addr_valid),
    .c_read_addr_ready(w_c_read_addr_ready), .c_read_data(w_c_read_data),
    .c_read_data_valid(w_c_read_data_valid), .c_write_addr(w_c_write_addr),
    .c_write_addr_valid(w_c_write_addr_valid), .c_write_data(w_c_write_data),
    .c_write_addr_ready(w_c_write_addr_ready), .c_write_resp_valid(w_c_write_resp_valid),
    .c_strobe(w_c_strobe), .c_size(w_c_size), .c_lu(w_c_lu),
    .d_read_addr(w_d_read_addr), .d_read_addr_valid(w_d_read_addr_valid),
    .d_write_addr(w_d_write_addr), .d_write_addr_valid(w_d_write_addr_valid),
    .d_write_data(w_d_write_data), .d_strobe(w_d_strobe), .d_size(w_d_size), .d_lu(w_d_lu),
    .d_read_addr_ready(w_d_read_addr_ready), .d_read_data(w_d_read_data),
    .d_read_data_valid(w_d_read_data_valid), .d_write_addr_ready(w_d_write_addr_ready),
    .d_write_resp_valid(w_d_write_resp_valid),
    .timeout_err(w_timeout_err), .timeout_ch(w_timeout_ch)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #100000;
    $display("FAIL global_time_limit: simulation still running, required to finish");
    $fatal(1);
  end

  typedef struct {
    string       name;
    int          ch;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    int          ar_dly;
    int          rsp_dly;
    logic [31:0] rdata;
    logic [2:0]  exp_ready;
    logic [2:0]  exp_resp;
    logic [31:0] exp_data;
  } vec_t;

  function automatic vec_t mk(input string n, input int ch, input bit wr,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [3:0] strb, input int ar_dly, input int rsp_dly,
                              input logic [31:0] rdata, input logic [2:0] er,
                              input logic [2:0] ep, input logic [31:0] ed);
    vec_t v;
    v.name = n; v.ch = ch; v.wr = wr; v.addr = addr; v.wdata = wdata; v.strb = strb;
    v.ar_dly = ar_dly; v.rsp_dly = rsp_dly; v.rdata = rdata;
    v.exp_ready = er; v.exp_resp = ep; v.exp_data = ed;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic clr();
    c_read_addr = '0; c_read_addr_valid = '0; c_write_addr = '0; c_write_addr_valid = '0;
    c_write_data = '0; c_strobe = '0; c_size = '0; c_lu = '0;
    d_read_addr_ready = 1'b0; d_read_data = '0; d_read_data_valid = 1'b0;
    d_write_addr_ready = 1'b0; d_write_resp_valid = 1'b0;
    w_c_read_addr = '0; w_c_read_addr_valid = '0; w_c_write_addr = '0; w_c_write_addr_valid = '0;
    w_c_write_data = '0; w_c_strobe = '0; w_c_size = '0; w_c_lu = '0;
    w_d_read_addr_ready = 1'b0; w_d_read_data = '0; w_d_read_data_valid = 1'b0;
    w_d_write_addr_ready = 1'b0; w_d_write_resp_valid = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge CLK); #1;
  endtask

  // One isolated transaction; the device side answers after the vector's delays.
  task automatic run_vec(input vec_t v);
    bit          accepted, done;
    int          wait_c, rsp_c, rdy_n, rsp_n;
    logic [2:0]  rdy, rsp, rdy_or, rsp_or, other_or;
    logic [31:0] data_seen, daddr_seen, dwdata_seen;
    accepted = 0; done = 0; wait_c = 0; rsp_c = 0; rdy_n = 0; rsp_n = 0;
    rdy_or = '0; rsp_or = '0; other_or = '0;
    data_seen = '0; daddr_seen = '0; dwdata_seen = '0;
    c_strobe[v.ch] = v.strb;
    c_size[v.ch]   = 2'b10;
    if (v.wr) begin
      c_write_addr[v.ch] = v.addr; c_write_data[v.ch] = v.wdata; c_write_addr_valid[v.ch] = 1'b1;
    end else begin
      c_read_addr[v.ch] = v.addr; c_read_addr_valid[v.ch] = 1'b1;
    end
    for (int cyc = 0; cyc < 40 && !done; cyc++) begin
      d_read_addr_ready = 1'b0; d_write_addr_ready = 1'b0;
      d_read_data_valid = 1'b0; d_write_resp_valid = 1'b0; d_read_data = '0;
      if (!accepted) begin
        if (d_read_addr_valid || d_write_addr_valid) begin
          if (wait_c == v.ar_dly) begin
            if (v.wr) d_write_addr_ready = 1'b1; else d_read_addr_ready = 1'b1;
          end
          wait_c++;
        end
      end else begin
        if (rsp_c == v.rsp_dly) begin
          if (v.wr) d_write_resp_valid = 1'b1;
          else begin d_read_data_valid = 1'b1; d_read_data = v.rdata; end
        end
        rsp_c++;
      end
      @(negedge CLK);
      if (d_read_addr_valid || d_write_addr_valid) begin
        daddr_seen  = v.wr ? d_write_addr : d_read_addr;
        dwdata_seen = d_write_data;
      end
      rdy = v.wr ? c_write_addr_ready : c_read_addr_ready;
      rsp = v.wr ? c_write_resp_valid : c_read_data_valid;
      other_or |= v.wr ? (c_read_addr_ready | c_read_data_valid)
                       : (c_write_addr_ready | c_write_resp_valid);
      rdy_or |= rdy;
      if (rdy != 0) rdy_n++;
      rsp_or |= rsp;
      if (rsp != 0) begin rsp_n++; data_seen = c_read_data; done = 1; end
      next_cycle();
      if (rdy != 0) begin
        accepted = 1;
        c_read_addr_valid = '0; c_write_addr_valid = '0;
      end
    end
    chk({v.name, "_completed"}, done, 1'b1);
    chk({v.name, "_ready"}, rdy_or, v.exp_ready);
    chk({v.name, "_ready_pulses"}, rdy_n, 1);
    chk({v.name, "_resp"}, rsp_or, v.exp_resp);
    chk({v.name, "_resp_pulses"}, rsp_n, 1);
    chk({v.name, "_other_op_quiet"}, other_or, 3'b000);
    chk({v.name, "_dev_addr"}, daddr_seen, v.addr);
    if (v.wr) chk({v.name, "_dev_wdata"}, dwdata_seen, v.wdata);
    else      chk({v.name, "_rdata"}, data_seen, v.exp_data);
    clr();
  endtask

  // Device never completes: returns cycles from first ADDR cycle to the response pulse.
  task automatic run_timeout(input int ch, input bit wr, input bit acc, output int dt,
                             output logic [2:0] rdy_v, output logic [2:0] rsp_v,
                             output logic [31:0] data);
    int         t0;
    bit         got;
    logic [2:0] rdy;
    t0 = -1; got = 0; dt = -1; rdy_v = '0; rsp_v = '0; data = '1;
    d_read_data = 32'hBAD0BAD0;
    if (wr) begin
      c_write_addr[ch] = 32'h500; c_write_data[ch] = 32'hFFFF0000;
      c_write_addr_valid[ch] = 1'b1; d_write_addr_ready = acc;
    end else begin
      c_read_addr[ch] = 32'h300; c_read_addr_valid[ch] = 1'b1; d_read_addr_ready = acc;
    end
    for (int cyc = 0; cyc < 30 && !got; cyc++) begin
      @(negedge CLK);
      if (t0 < 0 && (d_read_addr_valid || d_write_addr_valid)) t0 = cyc;
      rdy = wr ? c_write_addr_ready : c_read_addr_ready;
      if ((wr ? c_write_resp_valid : c_read_data_valid) != 0) begin
        got = 1; dt = cyc - t0; rdy_v = rdy;
        rsp_v = wr ? c_write_resp_valid : c_read_data_valid;
        data = c_read_data;
      end
      next_cycle();
      if (rdy != 0) begin c_read_addr_valid = '0; c_write_addr_valid = '0; end
    end
    chk("timeout_resp_seen", got, 1'b1);
    clr();
  endtask

  vec_t        vecs[5];
  logic [2:0]  rr_exp[4];
  logic [2:0]  rr_got[4];
  int          rr_cyc[4];
  int          n_rr, dt, n_w;
  logic [2:0]  rv, pv, kinds, wr_rdy, rd_rdy;
  logic [31:0] dv, wdat, waddr, rdat2;
  logic [3:0]  wstrb;
  logic [2:0]  rsp_kind_vec[2];
  bit          rsp_is_wr[2];
  logic [127:0] blk, blk_seen;
  logic [15:0] wstrb_seen;
  logic [2:0]  w_rsp_or;

  initial begin
    vecs[0] = mk("rd_ch1", 1, 0, 32'h100, 32'h0,        4'hF, 2, 1, 32'hCAFEF00D, 3'b010, 3'b010, 32'hCAFEF00D);
    vecs[1] = mk("wr_ch0", 0, 1, 32'h200, 32'h11223344, 4'hF, 0, 0, 32'h0,        3'b001, 3'b001, 32'h0);
    vecs[2] = mk("rd_ch2", 2, 0, 32'h3FC, 32'h0,        4'hF, 0, 0, 32'hDEADBEEF, 3'b100, 3'b100, 32'hDEADBEEF);
    vecs[3] = mk("wr_ch2", 2, 1, 32'h400, 32'hA5A55A5A, 4'h3, 1, 3, 32'h0,        3'b100, 3'b100, 32'h0);
    vecs[4] = mk("rd_ch0", 0, 0, 32'h104, 32'h0,        4'hF, 3, 3, 32'h0BADF00D, 3'b001, 3'b001, 32'h0BADF00D);
    rr_exp[0] = 3'b001; rr_exp[1] = 3'b010; rr_exp[2] = 3'b100; rr_exp[3] = 3'b001;

    // Reset dominates live requests and device handshakes.
    clr();
    RST_N = 1'b0;
    c_read_addr_valid = 3'b111; d_read_addr_ready = 1'b1; d_read_data_valid = 1'b1;
    d_read_data = 32'h12345678;
    repeat (3) next_cycle();
    @(negedge CLK);
    chk("rst_rd_ready", c_read_addr_ready, 3'b000);
    chk("rst_rd_valid", c_read_data_valid, 3'b000);
    chk("rst_rd_data", c_read_data, 32'h0);
    chk("rst_dev_valids", {d_read_addr_valid, d_write_addr_valid}, 2'b00);
    chk("rst_wr_outs", {c_write_addr_ready, c_write_resp_valid}, 6'b0);
    chk("rst_timeout", {timeout_err, timeout_ch}, 3'b000);
    next_cycle();
    RST_N = 1'b1;
    clr();
    next_cycle();

    // Round robin from pointer 0 with all channels always requesting.
    c_read_addr[0] = 32'h00; c_read_addr[1] = 32'h40; c_read_addr[2] = 32'h80;
    c_read_addr_valid = 3'b111;
    d_read_addr_ready = 1'b1; d_read_data_valid = 1'b1; d_read_data = 32'h5A5A0000;
    n_rr = 0;
    for (int cyc = 0; cyc < 30 && n_rr < 4; cyc++) begin
      @(negedge CLK);
      if (c_read_data_valid != 0) begin
        rr_got[n_rr] = c_read_data_valid; rr_cyc[n_rr] = cyc; n_rr++;
        chk("rr_data", c_read_data, 32'h5A5A0000);
      end
      next_cycle();
    end
    clr();
    chk("rr_count", n_rr, 4);
    for (int k = 0; k < 4; k++) chk($sformatf("rr_grant%0d", k), rr_got[k], rr_exp[k]);
    for (int k = 1; k < 4; k++) chk($sformatf("rr_spacing%0d", k), rr_cyc[k] - rr_cyc[k-1], 3);
    next_cycle();

    // Ch0 read+write together: write first, then read.
    c_read_addr[0] = 32'h204; c_write_addr[0] = 32'h200; c_write_data[0] = 32'h11223344;
    c_strobe[0] = 4'hF; c_size[0] = 2'b10;
    c_read_addr_valid[0] = 1'b1; c_write_addr_valid[0] = 1'b1;
    d_read_addr_ready = 1'b1; d_read_data_valid = 1'b1; d_read_data = 32'h77;
    d_write_addr_ready = 1'b1; d_write_resp_valid = 1'b1;
    n_w = 0; waddr = '0; wdat = '0; wstrb = '0; rdat2 = '0;
    for (int cyc = 0; cyc < 30 && n_w < 2; cyc++) begin
      @(negedge CLK);
      if (d_write_addr_valid) begin waddr = d_write_addr; wdat = d_write_data; wstrb = d_strobe; end
      if (c_write_resp_valid != 0 || c_read_data_valid != 0) begin
        rsp_is_wr[n_w] = (c_write_resp_valid != 0);
        rsp_kind_vec[n_w] = c_write_resp_valid | c_read_data_valid;
        if (c_read_data_valid != 0) rdat2 = c_read_data;
        n_w++;
      end
      wr_rdy = c_write_addr_ready; rd_rdy = c_read_addr_ready;
      next_cycle();
      if (wr_rdy[0]) c_write_addr_valid[0] = 1'b0;
      if (rd_rdy[0]) c_read_addr_valid[0] = 1'b0;
    end
    clr();
    chk("ww_count", n_w, 2);
    chk("ww_first_is_write", rsp_is_wr[0], 1'b1);
    chk("ww_first_vec", rsp_kind_vec[0], 3'b001);
    chk("ww_second_is_read", rsp_is_wr[1], 1'b0);
    chk("ww_second_vec", rsp_kind_vec[1], 3'b001);
    chk("ww_read_data", rdat2, 32'h77);
    chk("ww_dev_waddr", waddr, 32'h200);
    chk("ww_dev_wdata", wdat, 32'h11223344);
    chk("ww_dev_strobe", wstrb, 4'hF);
    next_cycle();

    // Watchdog: ch2 read accepted but never answered.
    run_timeout(2, 1'b0, 1'b1, dt, rv, pv, dv);
    chk("to_rd_latency", dt, 8);
    chk("to_rd_resp", pv, 3'b100);
    chk("to_rd_data_zero", dv, 32'h0);
    chk("to_rd_no_ready_at_resp", rv, 3'b000);
    @(negedge CLK);
    chk("to_rd_err", timeout_err, 1'b1);
    chk("to_rd_ch", timeout_ch, 2'd2);
    next_cycle();

    // Watchdog in ADDR: ready and response together; first channel kept.
    run_timeout(1, 1'b1, 1'b0, dt, rv, pv, dv);
    chk("to_wr_latency", dt, 8);
    chk("to_wr_ready", rv, 3'b010);
    chk("to_wr_resp", pv, 3'b010);
    @(negedge CLK);
    chk("to_wr_err_sticky", timeout_err, 1'b1);
    chk("to_wr_ch_first", timeout_ch, 2'd2);
    next_cycle();

    // Table: ordinary traffic still served after timeouts.
    for (int i = 0; i < 5; i++) begin
      run_vec(vecs[i]);
      next_cycle();
    end
    @(negedge CLK);
    chk("err_still_sticky", timeout_err, 1'b1);
    next_cycle();

    // Reset while ch1 waits in RESP; device answers during reset.
    c_read_addr[1] = 32'h180; c_read_addr_valid[1] = 1'b1; d_read_addr_ready = 1'b1;
    rv = '0;
    for (int cyc = 0; cyc < 10 && rv == 0; cyc++) begin
      @(negedge CLK);
      rv = c_read_addr_ready;
      next_cycle();
    end
    chk("rr_rst_accept", rv, 3'b010);
    c_read_addr_valid = '0;
    RST_N = 1'b0; d_read_data_valid = 1'b1; d_read_data = 32'h1234;
    @(negedge CLK);
    chk("rst_resp_no_valid", c_read_data_valid, 3'b000);
    chk("rst_resp_no_data", c_read_data, 32'h0);
    next_cycle();
    @(negedge CLK);
    chk("rst_next_c_outs", {c_read_addr_ready, c_read_data_valid, c_write_addr_ready, c_write_resp_valid}, 12'h0);
    chk("rst_next_d_valids", {d_read_addr_valid, d_write_addr_valid}, 2'b00);
    chk("rst_next_timeout", {timeout_err, timeout_ch}, 3'b000);
    next_cycle();
    RST_N = 1'b1; d_read_data_valid = 1'b0;
    // Pointer back at 0: ch0 beats ch2.
    c_read_addr_valid = 3'b101;
    rv = '0;
    for (int cyc = 0; cyc < 10 && rv == 0; cyc++) begin
      @(negedge CLK);
      rv = c_read_addr_ready;
      next_cycle();
    end
    chk("rst_ptr_zero_grant", rv, 3'b001);
    c_read_addr_valid = '0; d_read_data_valid = 1'b1;
    repeat (3) next_cycle();
    clr();
    next_cycle();

    // 128-bit block write on ch1.
    blk = 128'h0123456789ABCDEFFEDCBA9876543210;
    w_c_write_addr[1] = 32'h1000; w_c_write_data[1] = blk; w_c_strobe[1] = 16'hA5C3;
    w_c_write_addr_valid[1] = 1'b1;
    w_d_write_addr_ready = 1'b1; w_d_write_resp_valid = 1'b1;
    n_w = 0; w_rsp_or = '0; blk_seen = '0; wstrb_seen = '0;
    for (int cyc = 0; cyc < 8; cyc++) begin
      @(negedge CLK);
      if (w_d_write_addr_valid) begin blk_seen = w_d_write_data; wstrb_seen = w_d_strobe; end
      if (w_c_write_resp_valid != 0) begin n_w++; w_rsp_or |= w_c_write_resp_valid; end
      kinds = w_c_write_addr_ready;
      next_cycle();
      if (kinds[1]) w_c_write_addr_valid[1] = 1'b0;
    end
    clr();
    chk("w128_data", blk_seen, blk);
    chk("w128_strobe", wstrb_seen, 16'hA5C3);
    chk("w128_resp_vec", w_rsp_or, 3'b010);
    chk("w128_resp_pulses", n_w, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
